inst_decode_stage: RTL and testbench
====================================

// Module: inst_decode_stage
// PURPOSE
//  Registered, handshaked instruction-decode stage; successor to the combinational opcode ROM.
//  Decodes a stream of instruction words into ALU control flags, ldi, argument and immediate fields.
//  Adds two-word LDI (opcode word followed by immediate word), illegal-opcode flagging and a decoded-instruction counter.
//  Sits between instruction fetch (upstream valid/ready) and the ALU/register-file execute stage (downstream valid/ready).
// PARAMETERS
//  OPC_W  4   opcode field width, taken from word[OPC_W+ARG_W-1 -: OPC_W]; must be >= 4
//  ARG_W  4   argument field width, taken from word[ARG_W-1:0]
//  IMM_W  8   immediate width, taken from the second LDI word[IMM_W-1:0]; must be <= OPC_W+ARG_W
//  CNT_W  16  decoded-instruction counter width
// PORTS
//  clk            in   1            clock, rising edge
//  rst_n          in   1            asynchronous active-low reset
//  in_valid       in   1            upstream word valid
//  in_ready       out  1            stage accepts in_word this cycle
//  in_word        in   OPC_W+ARG_W  instruction or immediate word
//  out_valid      out  1            decoded instruction valid
//  out_ready      in   1            downstream accepts the decoded instruction
//  out_alu_flags  out  8            {ci,nb,ic,na,xo,no,sr,ss}
//  out_ldi        out  1            load-immediate
//  out_arg        out  ARG_W        argument field of the opcode word
//  out_imm        out  IMM_W        immediate (LDI only, else 0)
//  out_illegal    out  1            opcode not in the table
//  decode_count   out  CNT_W        count of decoded instructions handed downstream
// BEHAVIOUR
//  Reset: all out_* = 0, decode_count = 0, FSM = S_OP; asynchronous assert, synchronous-release domain.
//  Accept: in_valid & in_ready. in_ready = ~out_valid | out_ready (one-entry output register, no bubble under full throughput).
//  Output transfer: out_valid & out_ready. out_* are stable while out_valid & ~out_ready.
//  Opcode table, opcode zero-extended compare:
//    0 add 00000000 | 1 sub 11000000 | 2 xor 00100000 | 3 nor 00101100
//    4 and 01111100 | 5 srl 00000010 | 6 sra 00000011
//    all-ones LDI: flags 0, ldi=1 | any other opcode: flags 0, ldi=0, illegal=1
//  FSM:
//    S_OP: accepted non-LDI word -> load out_* next edge, out_valid=1 (latency 1 cycle), stay in S_OP.
//      Accepted LDI word -> latch out_arg, go to S_IMM; out_valid is not raised.
//    S_IMM: in_ready = ~out_valid | out_ready. Accepted word is the immediate, never decoded as an opcode.
//      It loads out_ldi=1, out_imm=word[IMM_W-1:0], out_valid=1, go to S_OP.
//      LDI latency is 1 cycle after immediate acceptance.
//  out_valid drops after transfer unless a new instruction completes in the same cycle; in that case it stays 1 with new data.
//  decode_count += 1 per output transfer; wraps modulo 2^CNT_W, no saturation.
//  Reset mid-LDI (in S_IMM): partial instruction is discarded, no output, FSM = S_OP.
//  in_valid with out_valid & ~out_ready: no accept; the word is held upstream.
// TESTING
//  1. Reset, then stream opcodes 0..6 (arg=5) with out_ready=1: one output per cycle, latency 1; flags per table; decode_count=7.
//  2. in_word=0xF0 then 0xA5: single output, ldi=1, imm=0xA5, arg=0, flags=0; 0xA5 is not decoded as an opcode.
//  3. Opcode 0x9: out_illegal=1, flags=0, ldi=0; counted (decode_count+1).
//  4. out_ready=0 for 3 cycles with in_valid=1: out_* stable, in_ready=0. Then out_ready=1: back-to-back transfers, no word lost or duplicated.
//  5. rst_n low for 1 cycle after 0xF0 accepted (S_IMM): outputs 0, next word 0x10 decodes as sub.
//  6. CNT_W=4, 17 transfers: decode_count wraps to 1.

Source files
------------

// File: rtl/inst_decode_stage.sv
// Instruction decode stage: opcode words -> ALU flags/ldi/arg/imm, two-word LDI, illegal flag, transfer counter.
// Latency 1 cycle from accepting the completing word; in_ready = ~out_valid | out_ready (holds upstream while stalled).
module inst_decode_stage #(
  parameter int OPC_W = 4,
  parameter int ARG_W = 4,
  parameter int IMM_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPC_W+ARG_W-1:0] in_word,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_alu_flags,
  output logic                   out_ldi,
  output logic [ARG_W-1:0]       out_arg,
  output logic [IMM_W-1:0]       out_imm,
  output logic                   out_illegal,
  output logic [CNT_W-1:0]       decode_count
);

  localparam int W = OPC_W + ARG_W;

  typedef enum logic {S_OP, S_IMM} state_t;

  state_t           state;
  logic [ARG_W-1:0] ldi_arg;
  logic [OPC_W-1:0] opc;
  logic [ARG_W-1:0] arg;
  logic [7:0]       dec_flags;
  logic             dec_ldi;
  logic             dec_illegal;
  logic             accept;
  logic             xfer;

  assign opc      = in_word[W-1 -: OPC_W];
  assign arg      = in_word[ARG_W-1:0];
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  // Flag order is {ci,nb,ic,na,xo,no,sr,ss}.
  always_comb begin
    dec_flags   = 8'h00;
    dec_ldi     = 1'b0;
    dec_illegal = 1'b0;
    case (opc)
      OPC_W'(0): dec_flags = 8'b0000_0000;
      OPC_W'(1): dec_flags = 8'b1100_0000;
      OPC_W'(2): dec_flags = 8'b0010_0000;
      OPC_W'(3): dec_flags = 8'b0010_1100;
      OPC_W'(4): dec_flags = 8'b0111_1100;
      OPC_W'(5): dec_flags = 8'b0000_0010;
      OPC_W'(6): dec_flags = 8'b0000_0011;
      default: begin
        if (opc == {OPC_W{1'b1}}) dec_ldi = 1'b1;
        else                      dec_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_OP;
      ldi_arg       <= '0;
      out_valid     <= 1'b0;
      out_alu_flags <= 8'h00;
      out_ldi       <= 1'b0;
      out_arg       <= '0;
      out_imm       <= '0;
      out_illegal   <= 1'b0;
      decode_count  <= '0;
    end else begin
      if (xfer) begin
        out_valid    <= 1'b0;
        decode_count <= decode_count + CNT_W'(1);
      end
      // accept implies the output register is empty or draining, so reloading it here is safe.
      if (accept) begin
        case (state)
          S_OP: begin
            if (dec_ldi) begin
              ldi_arg <= arg;
              state   <= S_IMM;
            end else begin
              out_valid     <= 1'b1;
              out_alu_flags <= dec_flags;
              out_ldi       <= 1'b0;
              out_arg       <= arg;
              out_imm       <= '0;
              out_illegal   <= dec_illegal;
            end
          end
          S_IMM: begin
            out_valid     <= 1'b1;
            out_alu_flags <= 8'h00;
            out_ldi       <= 1'b1;
            out_arg       <= ldi_arg;
            out_imm       <= in_word[IMM_W-1:0];
            out_illegal   <= 1'b0;
            state         <= S_OP;
          end
          default: state <= S_OP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: directed vector table, multi-cycle corner sequences, random stream vs. reference model.
module tb_inst_decode_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_word = 8'h00;

  logic       in_ready, out_valid, out_ldi, out_illegal;
  logic [7:0] out_alu_flags, out_imm;
  logic [3:0] out_arg;
  logic [15:0] decode_count;

  logic       in_ready4, out_valid4, out_ldi4, out_illegal4;
  logic [7:0] out_alu_flags4, out_imm4;
  logic [3:0] out_arg4;
  logic [3:0] decode_count4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_decode_stage #(.OPC_W(4), .ARG_W(4), .IMM_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_flags(out_alu_flags), .out_ldi(out_ldi),
    .out_arg(out_arg), .out_imm(out_imm), .out_illegal(out_illegal), .decode_count(decode_count)
  );

  inst_decode_stage #(.OPC_W(4), .ARG_W(4), .IMM_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_word(in_word),
    .out_valid(out_valid4), .out_ready(out_ready), .out_alu_flags(out_alu_flags4), .out_ldi(out_ldi4),
    .out_arg(out_arg4), .out_imm(out_imm4), .out_illegal(out_illegal4), .decode_count(decode_count4)
  );

  typedef struct {
    logic [7:0] word;
    logic [7:0] flags;
    logic       ldi;
    logic [7:0] imm;
    logic       illegal;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_word = 8'h00;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_flags", 32'(out_alu_flags), 0);
    chk("rst_ldi_imm_arg", 32'({out_ldi, out_illegal, out_arg, out_imm}), 0);
    chk("rst_count", 32'(decode_count), 0);
    chk("rst_count4", 32'(decode_count4), 0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Compares both instances' outputs against one expected decoded instruction.
  task automatic chk_out(input string nm, input logic [7:0] flags, input logic ldi,
                         input logic [3:0] arg, input logic [7:0] imm, input logic ill);
    chk({nm, "_valid"}, 32'(out_valid), 1);
    chk({nm, "_rec"}, 32'({out_alu_flags, out_ldi, out_arg, out_imm, out_illegal}),
        32'({flags, ldi, arg, imm, ill}));
    chk({nm, "_rec4"}, 32'({out_valid4, out_alu_flags4, out_ldi4, out_arg4, out_imm4, out_illegal4}),
        32'({1'b1, flags, ldi, arg, imm, ill}));
  endtask

  task automatic run_table(input int lo, input int hi);
    out_ready = 1'b1;
    for (int i = lo; i <= hi; i++) begin
      in_valid = 1'b1;
      in_word = vt[i].word;
      tick();
      chk_out($sformatf("vec%0d", i), vt[i].flags, vt[i].ldi, vt[i].word[3:0], vt[i].imm, vt[i].illegal);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 0);
  endtask

  // Reference model: decoded record from the opcode table, 22 bits {flags,ldi,arg,imm,illegal}.
  function automatic logic [21:0] ref_decode(input logic [7:0] w, input logic [7:0] imm_word);
    logic [7:0] tab[7];
    logic [3:0] op;
    tab = '{8'b0000_0000, 8'b1100_0000, 8'b0010_0000, 8'b0010_1100,
            8'b0111_1100, 8'b0000_0010, 8'b0000_0011};
    op = w[7:4];
    if (op == 4'hF) return {8'h00, 1'b1, w[3:0], imm_word, 1'b0};
    if (op < 4'd7)  return {tab[op], 1'b0, w[3:0], 8'h00, 1'b0};
    return {8'h00, 1'b0, w[3:0], 8'h00, 1'b1};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  words[$];
    logic [21:0] expq[$];
    logic [21:0] got, exp_rec;
    int          idx, ninstr;
    bit          done;

    vt[0] = '{8'h05, 8'b0000_0000, 1'b0, 8'h00, 1'b0};
    vt[1] = '{8'h15, 8'b1100_0000, 1'b0, 8'h00, 1'b0};
    vt[2] = '{8'h25, 8'b0010_0000, 1'b0, 8'h00, 1'b0};
    vt[3] = '{8'h35, 8'b0010_1100, 1'b0, 8'h00, 1'b0};
    vt[4] = '{8'h45, 8'b0111_1100, 1'b0, 8'h00, 1'b0};
    vt[5] = '{8'h55, 8'b0000_0010, 1'b0, 8'h00, 1'b0};
    vt[6] = '{8'h65, 8'b0000_0011, 1'b0, 8'h00, 1'b0};
    vt[7] = '{8'h9C, 8'b0000_0000, 1'b0, 8'h00, 1'b1};
    vt[8] = '{8'h70, 8'b0000_0000, 1'b0, 8'h00, 1'b1};
    vt[9] = '{8'hE3, 8'b0000_0000, 1'b0, 8'h00, 1'b1};

    // Opcodes 0..6, then illegal opcodes.
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 1);
    run_table(0, 6);
    chk("count_after_7", 32'(decode_count), 7);
    run_table(7, 9);
    chk("count_after_illegal", 32'(decode_count), 10);

    // Two-word LDI; the immediate must not be decoded.
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_word = 8'hF0;
    tick();
    chk("ldi_first_no_valid", 32'(out_valid), 0);
    in_word = 8'hA5;
    tick();
    chk_out("ldi", 8'h00, 1'b1, 4'h0, 8'hA5, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("ldi_single_out", 32'(out_valid), 0);
    chk("ldi_count", 32'(decode_count), 11);

    // Stall for 3 cycles, then back-to-back drain.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_word = 8'h23;
    tick();
    in_word = 8'h34;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out($sformatf("stall%0d", c), 8'b0010_0000, 1'b0, 4'h3, 8'h00, 1'b0);
      chk("stall_in_ready", 32'({in_ready, in_ready4}), 0);
    end
    out_ready = 1'b1;
    tick();
    chk_out("bb_nor", 8'b0010_1100, 1'b0, 4'h4, 8'h00, 1'b0);
    in_word = 8'h45;
    tick();
    chk_out("bb_and", 8'b0111_1100, 1'b0, 4'h5, 8'h00, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("bb_drained", 32'(out_valid), 0);
    chk("bb_count", 32'(decode_count), 14);

    // Reset while waiting for the LDI immediate.
    in_valid = 1'b1;
    in_word = 8'hF7;
    tick();
    do_reset();
    in_valid = 1'b1;
    in_word = 8'h10;
    tick();
    chk_out("post_rst_sub", 8'b1100_0000, 1'b0, 4'h0, 8'h00, 1'b0);
    in_valid = 1'b0;
    tick();

    // 17 transfers: 4-bit counter wraps to 1.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_word = {4'(i % 7), 4'(i)};
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_count4", 32'(decode_count4), 1);
    chk("wrap_count16", 32'(decode_count), 17);

    // Random stream with random stalls against the reference model.
    do_reset();
    while (words.size() < 240) begin
      if ($urandom_range(0, 3) == 0) begin
        words.push_back({4'hF, 4'($urandom)});
        words.push_back(8'($urandom));
      end else begin
        words.push_back(8'($urandom));
      end
    end
    if (words[words.size()-1][7:4] == 4'hF) words.push_back(8'h5A);
    idx = 0;
    while (idx < words.size()) begin
      if (words[idx][7:4] == 4'hF) begin
        if (idx + 1 < words.size()) expq.push_back(ref_decode(words[idx], words[idx+1]));
        else expq.push_back(ref_decode(words[idx], 8'h00));
        idx += 2;
      end else begin
        expq.push_back(ref_decode(words[idx], 8'h00));
        idx += 1;
      end
    end
    ninstr = expq.size();
    idx = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      in_valid = (idx < words.size()) && ($urandom_range(0, 3) != 0);
      in_word = (idx < words.size()) ? words[idx] : 8'h00;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        got = {out_alu_flags, out_ldi, out_arg, out_imm, out_illegal};
        if (expq.size() == 0) begin
          chk("rnd_extra_output", 32'(got), 32'h3FFFFF);
        end else begin
          exp_rec = expq.pop_front();
          chk("rnd_record", 32'(got), 32'(exp_rec));
        end
      end
      if (in_valid && in_ready) idx++;
      tick();
      done = (idx >= words.size()) && (expq.size() == 0);
    end
    if (!done) chk("rnd_timeout_remaining", 32'(expq.size()), 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("rnd_count16", 32'(decode_count), 32'(ninstr));
    chk("rnd_count4", 32'(decode_count4), 32'(ninstr % 16));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
